// File: rtl/key_pkg.sv
// Shared keypad constants and the key index mapping used here and by the encoder.
// Latency: n/a (package only).
// Backpressure: n/a.
package key_pkg;

    localparam int unsigned NROW = 5;
    localparam int unsigned NCOL = 5;
    localparam int unsigned NKEY = NROW * NCOL;

    function automatic int unsigned key_idx(input int unsigned c, input int unsigned r);
        return c * NROW + r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Whole-frame debouncer: accepts a new key map after DEB_CNT identical frames, pulses new presses.
// Latency: btn_ok/key_state update on the accepting frame-end edge (visible next cycle).
// Backpressure: none; btn_ok is a single-cycle pulse with no handshake.
module key_debounce
    import key_pkg::*;
#(
    parameter int DEB_CNT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NKEY-1:0] next_frame,
    input  logic            frame_end,
    output logic [NKEY-1:0] key_state,
    output logic [NKEY-1:0] btn_ok
);

    localparam int SW = $clog2(DEB_CNT + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEB_CNT);

    logic [NKEY-1:0] last_frame;
    logic [SW-1:0]   stable;
    logic [SW-1:0]   stable_nxt;
    logic            accept;

    always_comb begin
        stable_nxt = stable;
        accept     = 1'b0;
        if (frame_end) begin
            if (next_frame == last_frame) begin
                stable_nxt = (stable == STABLE_MAX) ? stable : stable + 1'b1;
            end else begin
                stable_nxt = SW'(1);
            end
            accept = (stable_nxt == STABLE_MAX) && (next_frame != key_state);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_frame <= '0;
            stable     <= '0;
            key_state  <= '0;
            btn_ok     <= '0;
        end else begin
            stable <= stable_nxt;
            btn_ok <= '0;
            if (frame_end) begin
                last_frame <= next_frame;
            end
            // Releases only change key_state; only newly set bits pulse.
            if (accept) begin
                key_state <= next_frame;
                btn_ok    <= next_frame & ~key_state;
            end
        end
    end

endmodule

// File: rtl/key_scan.sv
// 5x5 keypad scanner: drives columns, samples synchronised rows, hands whole frames to the debouncer.
// Latency: one frame is 5*SCAN_DIV cycles; a stable press is reported after DEB_CNT full frames.
// Backpressure: none; outputs are free-running pulses and levels.
module key_scan
    import key_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CNT  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NROW-1:0] row,
    output logic [NCOL-1:0] col,
    output logic [NKEY-1:0] btn_ok,
    output logic [NKEY-1:0] key_state
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [2:0]    C_LAST   = 3'(NCOL - 1);

    logic [NROW-1:0] row_m;
    logic [NROW-1:0] row_s;
    logic [DW-1:0]   div;
    logic [2:0]      c;
    logic            sample;
    logic            frame_end;
    logic [NKEY-1:0] next_frame;
    // The last column is never stored: it goes straight into next_frame on the frame-end edge.
    logic [NROW-1:0] raw_col [NCOL-1];

    assign sample    = (div == DIV_LAST);
    assign frame_end = sample && (c == C_LAST);
    assign col       = ~(NCOL'(1) << c);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_m <= '1;
            row_s <= '1;
        end else begin
            row_m <= row;
            row_s <= row_m;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div <= '0;
            c   <= '0;
            for (int i = 0; i < NCOL - 1; i++) begin
                raw_col[i] <= '0;
            end
        end else if (sample) begin
            div <= '0;
            c   <= (c == C_LAST) ? 3'd0 : c + 3'd1;
            if (c != C_LAST) begin
                raw_col[c[1:0]] <= ~row_s;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    for (genvar ci = 0; ci < NCOL - 1; ci++) begin : g_frame
        assign next_frame[key_idx(ci, 0) +: NROW] = raw_col[ci];
    end
    assign next_frame[key_idx(NCOL - 1, 0) +: NROW] = ~row_s;

    key_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .next_frame (next_frame),
        .frame_end  (frame_end),
        .key_state  (key_state),
        .btn_ok     (btn_ok)
    );

endmodule
